// File: rtl/message_buffer.sv
// Synchronous FIFO of whole messages with full/empty flags.
// Writes and reads arrive pre-qualified from the slicer, so no guard logic is needed here.
module message_buffer #(
  parameter int WIDTH     = 128,
  parameter int DEPTH     = 16,
  parameter int LOG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam logic [LOG_DEPTH:0] FULL_COUNT = (LOG_DEPTH+1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH:0]   count;

  // NOTE: storage is not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);

endmodule

// File: rtl/message_slicer.sv
// Buffers wide messages and streams each one out as N_SLICES slices, MS slice first,
// one slice per cycle with no gaps; a sticky error flags writes dropped while full.
module message_slicer #(
  parameter int N_SLICES          = 4,
  parameter int WIDTH             = 32,
  parameter int BUFFER_LENGTH     = 16,
  parameter int LOG_BUFFER_LENGTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH*N_SLICES-1:0] in_data,
  input  logic                      in_nd,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_nd,
  output logic                      error
);

  localparam int              CNT_W      = $clog2(N_SLICES);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N_SLICES - 1);

  logic [WIDTH*N_SLICES-1:0] head;
  logic                      full;
  logic                      empty;
  logic [CNT_W-1:0]          slice_cnt;
  logic [WIDTH-1:0]          slice;
  logic                      pop;
  logic                      push;
  logic                      overflow;

  // A pop frees the head slot in the same edge, so a write into a full FIFO may still land.
  always_comb begin
    pop      = !empty && (slice_cnt == LAST_SLICE);
    push     = in_nd && (!full || pop);
    overflow = in_nd && full && !pop;
    slice    = head[(N_SLICES - 1 - int'(slice_cnt))*WIDTH +: WIDTH];
  end

  message_buffer #(
    .WIDTH     (WIDTH * N_SLICES),
    .DEPTH     (BUFFER_LENGTH),
    .LOG_DEPTH (LOG_BUFFER_LENGTH)
  ) u_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // rst_n is active-high here: a 1 clears the block.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      slice_cnt <= '0;
      out_data  <= '0;
      out_nd    <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (overflow) error <= 1'b1;
      if (!empty) begin
        out_data  <= slice;
        out_nd    <= 1'b1;
        slice_cnt <= (slice_cnt == LAST_SLICE) ? '0 : slice_cnt + 1'b1;
      end else begin
        out_nd    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_message_slicer.sv
// Randomised and directed bench for message_slicer; the reference model is a queue
// of pending output slices from which FIFO occupancy and pop timing are derived.
module tb_message_slicer;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int BL  = 4;
  localparam int LBL = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic           in_nd = 1'b0;
  logic [W-1:0]   out_data;
  logic           out_nd;
  logic           error;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q [$];
  logic         exp_nd   = 1'b0;
  logic [W-1:0] exp_data = '0;
  logic         exp_err  = 1'b0;

  message_slicer #(
    .N_SLICES          (N),
    .WIDTH             (W),
    .BUFFER_LENGTH     (BL),
    .LOG_BUFFER_LENGTH (LBL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_nd    (in_nd),
    .out_data (out_data),
    .out_nd   (out_nd),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Pending slices of all messages not yet fully emitted: the head message may be
  // partial, so occupancy is ceil(size/N) and the head is on its last slice when size%N==1.
  task automatic model_edge(input logic rst, input logic nd, input logic [N*W-1:0] data);
    int occ;
    bit pop;
    bit acc;
    if (rst) begin
      exp_q.delete();
      exp_nd   = 1'b0;
      exp_data = '0;
      exp_err  = 1'b0;
    end else begin
      occ = (exp_q.size() + N - 1) / N;
      pop = (exp_q.size() % N) == 1;
      acc = nd && (occ < BL || pop);
      if (nd && !acc) exp_err = 1'b1;
      if (exp_q.size() > 0) begin
        exp_data = exp_q.pop_front();
        exp_nd   = 1'b1;
      end else begin
        exp_nd   = 1'b0;
      end
      if (acc)
        for (int i = N - 1; i >= 0; i--) exp_q.push_back(data[i*W +: W]);
    end
  endtask

  task automatic cycle(input logic rst, input logic nd, input logic [N*W-1:0] data);
    rst_n   = rst;
    in_nd   = nd;
    in_data = data;
    @(posedge clk);
    model_edge(rst, nd, data);
    #1;
    check("out_nd",   32'(out_nd),   32'(exp_nd));
    check("out_data", 32'(out_data), 32'(exp_data));
    check("error",    32'(error),    32'(exp_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'(i * 7));
  endtask

  initial begin
    // Reset state
    cycle(1'b1, 1'b1, 32'hDEADBEEF);
    cycle(1'b1, 1'b0, '0);
    check("reset_out_nd", 32'(out_nd), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);

    // Single message
    cycle(1'b0, 1'b1, 32'hA1B2C3D4);
    idle(6);
    check("single_no_error", 32'(error), 32'd0);

    // Three back-to-back messages
    cycle(1'b0, 1'b1, 32'h01020304);
    cycle(1'b0, 1'b1, 32'h11121314);
    cycle(1'b0, 1'b1, 32'h21222324);
    idle(14);

    // Write exactly on the pop of the only entry
    cycle(1'b0, 1'b1, 32'h55667788);
    idle(3);
    cycle(1'b0, 1'b1, 32'h99AABBCC);
    idle(6);

    // Six back-to-back messages: overflow on the sixth
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 32'h30313233 + 32'(i) * 32'h10101010);
    check("overflow_error", 32'(error), 32'd1);
    idle(24);
    check("overflow_sticky", 32'(error), 32'd1);

    // Reset during slice 2, then a fresh message
    cycle(1'b0, 1'b1, 32'hC0C1C2C3);
    idle(2);
    cycle(1'b1, 1'b1, 32'hFFFFFFFF);
    check("mid_reset_nd", 32'(out_nd), 32'd0);
    idle(3);
    cycle(1'b0, 1'b1, 32'hE0E1E2E3);
    idle(6);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      int dens;
      dens = (i / 150) % 2 == 0 ? 40 : 90;
      cycle($urandom_range(99) < 1, $urandom_range(99) < dens, $urandom);
    end
    idle(24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
